// File: rtl/mux_sweep.sv
// Built-in sweep engine for a mux-under-test: walks every {sel,stim} vector,
// waits SETTLE cycles per vector, then captures mux_in into a truth table.
module mux_sweep #(
    parameter int SEL_W  = 3,
    parameter int STIM_W = 2,
    parameter int SETTLE = 2,
    localparam int IDX_W = SEL_W + STIM_W,
    localparam int V     = 1 << IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               mux_in,
    output logic [SEL_W-1:0]   sel,
    output logic [STIM_W-1:0]  stim,
    output logic               busy,
    output logic               done,
    output logic [V-1:0]       result,
    output logic [IDX_W:0]     ones_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    // Vector is only presented while actively sweeping; idle/done park at 0.
    logic sweeping;
    assign sweeping = (state == DRIVE) || (state == SAMPLE);
    assign sel      = sweeping ? idx[IDX_W-1:STIM_W] : '0;
    assign stim     = sweeping ? idx[STIM_W-1:0]     : '0;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            result     <= '0;
            ones_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state      <= DRIVE;
                        idx        <= '0;
                        cnt        <= '0;
                        result     <= '0;
                        ones_count <= '0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        idx   <= '0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    // Capture happens even when aborting on this cycle.
                    result[idx] <= mux_in;
                    ones_count  <= ones_count + (IDX_W + 1)'(mux_in);
                    if (abort) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (idx == '1) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    // Registered pulse lands in the cycle after DONE.
                    state <= IDLE;
                    idx   <= '0;
                    done  <= !abort;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sweep.sv
// Randomised truth-table sweeps on a default instance plus a small-parameter
// instance, checked cycle by cycle against a vector-timing reference model.
module tb_mux_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance: 32 vectors, 3 cycles each
    logic        start0 = 1'b0, abort0 = 1'b0;
    logic [2:0]  sel0;
    logic [1:0]  stim0;
    logic        busy0, done0;
    logic [31:0] result0;
    logic [5:0]  ones0;
    logic [31:0] tbl;
    logic        mux0;
    assign mux0 = tbl[{sel0, stim0}];

    mux_sweep dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .mux_in(mux0),
        .sel(sel0), .stim(stim0), .busy(busy0), .done(done0),
        .result(result0), .ones_count(ones0)
    );

    // small instance: 4 vectors, 2 cycles each, mux_in = ~stim[0]
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [0:0] sel1, stim1;
    logic       busy1, done1;
    logic [3:0] result1;
    logic [2:0] ones1;

    mux_sweep #(.SEL_W(1), .STIM_W(1), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .mux_in(~stim1[0]),
        .sel(sel1), .stim(stim1), .busy(busy1), .done(done1),
        .result(result1), .ones_count(ones1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt(input logic [31:0] v, input int k);
        int c = 0;
        for (int i = 0; i < k; i++) c += int'(v[i]);
        return c;
    endfunction

    // One sweep on dut0. abortAt/restartAt/rstAt: cycle index after the start
    // edge at which that event is driven (-1 = never).
    task automatic sweep0(input logic [31:0] t, input int abortAt,
                          input int restartAt, input int rstAt);
        int nEnd, k;
        logic [31:0] expRes;
        tbl = t;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        nEnd = (abortAt >= 0) ? abortAt + 3 : 99;
        for (int n = 0; n <= nEnd; n++) begin
            if (n == 0) begin
                chk("clr_result", result0, 0);
                chk("clr_ones", ones0, 0);
            end
            if (abortAt >= 0 && n > abortAt) begin
                chk("abt_busy", busy0, 0);
                chk("abt_done", done0, 0);
                chk("abt_sel", sel0, 0);
                chk("abt_stim", stim0, 0);
            end else if (n < 96) begin
                chk("run_busy", busy0, 1);
                chk("run_done", done0, 0);
                chk("run_sel", sel0, (n / 3) / 4);
                chk("run_stim", stim0, (n / 3) % 4);
            end else if (n == 96) begin
                chk("fin_busy", busy0, 1);
                chk("fin_sel", {sel0, stim0}, 0);
                chk("fin_done", done0, 0);
            end else begin
                chk("end_busy", busy0, 0);
                chk("end_done", done0, (n == 97) ? 1 : 0);
            end
            if (n == rstAt) begin
                rst = 1'b1;
                #1;
                chk("arst_out", {sel0, stim0, busy0, done0, ones0}, 0);
                chk("arst_result", result0, 0);
                @(posedge clk); #1 rst = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("post_rst_idle", {busy0, done0}, 0);
                end
                return;
            end
            abort0 = (n == abortAt);
            start0 = (n == restartAt);
            @(posedge clk); #1;
            abort0 = 1'b0;
            start0 = 1'b0;
        end
        k = (abortAt >= 0) ? (abortAt + 1) / 3 : 32;
        if (k > 32) k = 32;
        expRes = (k == 32) ? t : (t & ((32'd1 << k) - 32'd1));
        chk("result", result0, expRes);
        chk("ones", ones0, popcnt(t, k));
        repeat (4) @(posedge clk);
        #1;
        chk("hold_result", result0, expRes);
    endtask

    initial begin
        tbl = '0;
        #1;
        chk("rst_out", {sel0, stim0, busy0, done0, ones0}, 0);
        chk("rst_result", result0, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_busy", busy0, 0);
        end

        // mux_in = stim[0]
        sweep0(32'hAAAA_AAAA, -1, -1, -1);
        chk("stim0_result", result0, 32'hAAAA_AAAA);
        chk("stim0_ones", ones0, 16);
        // mux_in = (sel == 7)
        sweep0(32'hF000_0000, -1, -1, -1);
        chk("sel7_result", result0, 32'hF000_0000);
        chk("sel7_ones", ones0, 4);
        // abort after 10 cycles
        sweep0(32'hFFFF_FFFF, 10, -1, -1);
        chk("abort_hi_bits", result0[31:4], 0);
        // abort during the final SAMPLE cycle: capture kept, no done
        sweep0($urandom, 95, -1, -1);
        // start re-pulsed mid-sweep is ignored
        sweep0($urandom, -1, 40, -1);
        // all-ones table: ones_count reaches V without wrapping
        sweep0(32'hFFFF_FFFF, -1, -1, -1);
        chk("full_ones", ones0, 32);
        // async reset mid-sweep, then a full sweep
        sweep0($urandom, -1, -1, 50);
        sweep0($urandom, -1, -1, -1);
        repeat (3) sweep0($urandom, -1, -1, -1);
        sweep0($urandom, $urandom_range(0, 95), -1, -1);

        // abort and start together in IDLE: stays idle
        @(posedge clk); #1 begin start0 = 1'b1; abort0 = 1'b1; end
        @(posedge clk); #1 begin start0 = 1'b0; abort0 = 1'b0; end
        chk("abort_wins", busy0, 0);
        @(posedge clk); #1;
        chk("abort_wins2", busy0, 0);

        // small instance: done 9 edges after the start edge
        begin
            int cyc = 0;
            start1 = 1'b1;
            @(posedge clk); #1 start1 = 1'b0;
            while (!done1 && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("small_done_cyc", cyc, 9);
            chk("small_result", result1, 4'b0101);
            chk("small_ones", ones1, 2);
            @(posedge clk); #1;
            chk("small_done_pulse", {busy1, done1}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
